i2s_slave_rx: RTL and testbench

- I2S slave receiver: the codec-side counterpart to the apb4_i2s master-mode transmitter.
- Accepts externally driven SCK/WS/SD, oversamples them on the system clock, and deserialises left/right words.
- Stores completed stereo frames in a small FIFO with a valid/ready read port.
- Used as the audio-in path and as a loopback checker for the existing I2S master.

---
 rtl/i2s_slave_rx.sv | 231 +++++++++++++++++++++++
 tb/tb_i2s_slave_rx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_slave_rx
// Brief    : I2S slave receiver. Oversamples SCK/WS/SD on clk_i, deserialises
//            stereo frames and buffers them in a valid/ready FIFO.
//            Optional build macro I2S_RX_LENCHK_EN adds sticky len_err_o.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_slave_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  fmt_i,
    input  logic [1:0]            wlen_i,
    input  logic                  i2s_sck_i,
    input  logic                  i2s_ws_i,
    input  logic                  i2s_sd_i,
    output logic                  frm_valid_o,
    input  logic                  frm_ready_i,
    output logic [DATA_WIDTH-1:0] frm_left_o,
    output logic [DATA_WIDTH-1:0] frm_right_o,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i,
`ifdef I2S_RX_LENCHK_EN
    output logic                  len_err_o,
`endif
    output logic                  busy_o
);
    localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [5:0]       DW_CAP   = (DATA_WIDTH >= 32) ? 6'd32 : 6'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    logic [2:0]            sck_sync_q, sck_sync_d;
    logic [1:0]            ws_sync_q, ws_sync_d;
    logic [1:0]            sd_sync_q, sd_sync_d;
    logic                  ws_hist_q, ws_hist_d;
    state_t                state_q, state_d;
    logic                  fmt_q, fmt_d;
    logic [1:0]            wlen_q, wlen_d;
    logic [31:0]           shift_q, shift_d;
    logic [5:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
    logic                  ovf_q, ovf_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_left_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_right_q [FIFO_DEPTH];

    logic                  sck_rise, ws_s, sd_s, ws_change;
    logic                  start_left, word_close, new_fmt, bit_take;
    logic                  push, pop, push_ok;
    logic [5:0]            word_len, keep_len, cnt_shift, close_cnt;
    logic [31:0]           shift_in, close_bits, close_word;
    logic [DATA_WIDTH-1:0] close_out;

    // Received bits sit in the low cnt bits; move them to the MSBs of the
    // word (zero-filling missing LSBs) and sign-extend from the kept width.
    function automatic logic [31:0] align_word(input logic [31:0] word_bits,
                                               input logic [5:0]  cnt,
                                               input logic [5:0]  keep);
        logic [31:0] msb_aligned;
        msb_aligned = word_bits << (6'd32 - cnt);
        return 32'($signed(msb_aligned) >>> (6'd32 - keep));
    endfunction

    assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
    assign ws_s      = ws_sync_q[1];
    assign sd_s      = sd_sync_q[1];
    assign ws_change = sck_rise && (ws_s != ws_hist_q);

    always_comb begin
        case (wlen_q)
            2'd0:    word_len = 6'd16;
            2'd1:    word_len = 6'd24;
            default: word_len = 6'd32;
        endcase
    end

    // Philips closes a word with the bit sampled at the WS change; left-justified
    // closes it before that bit, which instead starts the next word.
    assign bit_take   = bit_cnt_q < word_len;
    assign shift_in   = bit_take ? {shift_q[30:0], sd_s} : shift_q;
    assign cnt_shift  = bit_take ? bit_cnt_q + 6'd1 : bit_cnt_q;
    assign close_bits = fmt_q ? shift_q : shift_in;
    assign close_cnt  = fmt_q ? bit_cnt_q : cnt_shift;
    assign keep_len   = (word_len > DW_CAP) ? DW_CAP : word_len;
    assign close_word = align_word(close_bits, close_cnt, keep_len);
    assign new_fmt    = (state_q == ST_IDLE) ? fmt_i : fmt_q;
    assign start_left = ws_change && !ws_s && (state_q == ST_IDLE);
    assign word_close = en_i && ws_change && (state_q != ST_IDLE);

    generate
        if (DATA_WIDTH > 32) begin : g_out_wide
            assign close_out = {{(DATA_WIDTH-32){close_word[31]}}, close_word};
        end else begin : g_out_narrow
            assign close_out = close_word[DATA_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        sck_sync_d  = {sck_sync_q[1:0], i2s_sck_i};
        ws_sync_d   = {ws_sync_q[0], i2s_ws_i};
        sd_sync_d   = {sd_sync_q[0], i2s_sd_i};
        ws_hist_d   = sck_rise ? ws_s : ws_hist_q;
        state_d     = state_q;
        fmt_d       = fmt_q;
        wlen_d      = wlen_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        left_hold_d = left_hold_q;
        push        = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else if (start_left || word_close) begin
            shift_d   = new_fmt ? {31'd0, sd_s} : 32'd0;
            bit_cnt_d = new_fmt ? 6'd1 : 6'd0;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_LEFT;
                    fmt_d   = fmt_i;
                    wlen_d  = wlen_i;
                end
                ST_LEFT: begin
                    state_d     = ST_RIGHT;
                    left_hold_d = close_out;
                end
                default: begin
                    state_d = ST_LEFT;
                    push    = 1'b1;
                end
            endcase
        end else if (sck_rise && (state_q != ST_IDLE)) begin
            shift_d   = shift_in;
            bit_cnt_d = cnt_shift;
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pop     = frm_valid_o && frm_ready_i;
    assign push_ok = push && ((count_q != FULL_CNT) || pop);

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d = (push && !push_ok) ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync_q  <= '0;
            ws_sync_q   <= '0;
            sd_sync_q   <= '0;
            ws_hist_q   <= 1'b0;
            state_q     <= ST_IDLE;
            fmt_q       <= 1'b0;
            wlen_q      <= 2'd0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            left_hold_q <= '0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_left_q[i]  <= '0;
                mem_right_q[i] <= '0;
            end
        end else begin
            sck_sync_q  <= sck_sync_d;
            ws_sync_q   <= ws_sync_d;
            sd_sync_q   <= sd_sync_d;
            ws_hist_q   <= ws_hist_d;
            state_q     <= state_d;
            fmt_q       <= fmt_d;
            wlen_q      <= wlen_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            left_hold_q <= left_hold_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            if (push_ok) begin
                mem_left_q[wr_ptr_q]  <= left_hold_q;
                mem_right_q[wr_ptr_q] <= close_out;
            end
        end
    end

`ifdef I2S_RX_LENCHK_EN
    logic len_err_q, len_err_d;

    always_comb begin
        len_err_d = (word_close && (close_cnt < word_len)) ? 1'b1
                  : (ovf_clr_i ? 1'b0 : len_err_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= len_err_d;
        end
    end

    assign len_err_o = len_err_q;
`endif

    assign frm_valid_o = (count_q != '0);
    assign frm_left_o  = mem_left_q[rd_ptr_q];
    assign frm_right_o = mem_right_q[rd_ptr_q];
    assign ovf_o       = ovf_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2s_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_slave_rx
// Brief    : Self-checking bench for i2s_slave_rx: bit-level I2S master,
//            word-level expected-frame model and a handshake scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_slave_rx;
    logic        clk = 1'b0;
    logic        rst, en, fmt, sck, ws, sd, ready, ovf_clr;
    logic [1:0]  wlen;
    logic        frm_valid, ovf, busy;
    logic [31:0] frm_left, frm_right;
`ifdef I2S_RX_LENCHK_EN
    logic        len_err;
`endif

    always #5 clk = ~clk;

    i2s_slave_rx #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .fmt_i       (fmt),
        .wlen_i      (wlen),
        .i2s_sck_i   (sck),
        .i2s_ws_i    (ws),
        .i2s_sd_i    (sd),
        .frm_valid_o (frm_valid),
        .frm_ready_i (ready),
        .frm_left_o  (frm_left),
        .frm_right_o (frm_right),
        .ovf_o       (ovf),
        .ovf_clr_i   (ovf_clr),
`ifdef I2S_RX_LENCHK_EN
        .len_err_o   (len_err),
`endif
        .busy_o      (busy)
    );

    typedef struct {
        logic [31:0] l;
        int          nl;
        int          sl;
        logic [31:0] r;
        int          nr;
        int          sr;
    } tx_t;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
    } frame_t;

    tx_t    tx_q[$];
    frame_t exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    logic   model_ovf = 1'b0;
    logic   carry = 1'b0;
    logic   cur_fmt = 1'b0;
    int     cur_wl = 32;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for frm_valid_o", name);
    endtask

    // Expected sample: first W bits of the slot MSB-first, missing LSBs zero,
    // interpreted as a W-bit two's-complement number.
    function automatic logic [31:0] model_word(input logic [31:0] word, input int nbits,
                                               input int slot, input int wl);
        longint val = 0;
        int     got = 0;
        for (int i = 0; i < slot; i++) begin
            longint d = 0;
            if (i < nbits) d = longint'((word >> (nbits - 1 - i)) & 32'd1);
            if (got < wl) begin
                val = val * 2 + d;
                got++;
            end
        end
        val = val * (longint'(1) << (wl - got));
        if (val >= (longint'(1) << (wl - 1))) val = val - (longint'(1) << wl);
        return 32'(val);
    endfunction

    task automatic sck_bit(input logic ws_v, input logic sd_v);
        @(negedge clk);
        ws  = ws_v;
        sd  = sd_v;
        sck = 1'b0;
        repeat (8) @(negedge clk);
        sck = 1'b1;
        repeat (7) @(negedge clk);
    endtask

    task automatic send_slot(input logic ws_v, input logic [31:0] word, input int nbits, input int slot);
        for (int i = 0; i < slot; i++) begin
            logic d;
            d = 1'b0;
            if (i < nbits) d = word[nbits-1-i];
            if (cur_fmt) begin
                sck_bit(ws_v, d);
            end else begin
                sck_bit(ws_v, carry);
                carry = d;
            end
        end
    endtask

    task automatic run_stream(input logic f, input logic [1:0] wl_code);
        int     lat;
        bit     timed;
        frame_t fr;
        timed = (tx_q.size() == 1) && (exp_q.size() == 0) && !frm_valid;
        @(posedge clk); #1;
        fmt = f; wlen = wl_code; en = 1'b1;
        cur_fmt = f;
        carry   = 1'b0;
        cur_wl  = (wl_code == 2'd0) ? 16 : (wl_code == 2'd1) ? 24 : 32;
        send_slot(1'b1, 32'd0, 0, 4);
        foreach (tx_q[k]) begin
            send_slot(1'b0, tx_q[k].l, tx_q[k].nl, tx_q[k].sl);
            send_slot(1'b1, tx_q[k].r, tx_q[k].nr, tx_q[k].sr);
        end
        @(negedge clk);
        ws  = 1'b0;
        sd  = cur_fmt ? 1'b0 : carry;
        sck = 1'b0;
        repeat (8) @(negedge clk);
        sck = 1'b1;
        lat = 0;
        while (!frm_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        if (timed) begin
            n_cmp++;
            if (!frm_valid || lat > 4) begin
                n_err++;
                $display("FAIL close_latency: valid=%0b after %0d cycles, required within 4", frm_valid, lat);
            end
        end
        repeat (8) @(negedge clk);
        sck = 1'b0;
        foreach (tx_q[k]) begin
            fr.l = model_word(tx_q[k].l, tx_q[k].nl, tx_q[k].sl, cur_wl);
            fr.r = model_word(tx_q[k].r, tx_q[k].nr, tx_q[k].sr, cur_wl);
            if (exp_q.size() < 4) exp_q.push_back(fr);
            else model_ovf = 1'b1;
        end
        tx_q.delete();
        @(posedge clk); #1;
        en = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (!frm_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!frm_valid) fail_timeout(name);
    endtask

    task automatic pop_one();
        @(posedge clk); #1;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard: every accepted frame must match the head of the model queue.
    always @(negedge clk) begin
        frame_t f;
        if (!rst && frm_valid && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_spurious: got frame %h/%h, required none", frm_left, frm_right);
            end else begin
                f = exp_q.pop_front();
                check("sb_left", frm_left, f.l);
                check("sb_right", frm_right, f.r);
            end
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; fmt = 1'b0; wlen = 2'd2;
        sck = 1'b0; ws = 1'b0; sd = 1'b0; ready = 1'b0; ovf_clr = 1'b0;
        repeat (4) @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, frm_valid}, 32'd0);
        check("rst_left", frm_left, 32'd0);
        check("rst_right", frm_right, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Philips, 32-bit words
        tx_q.push_back('{32'h12345678, 32, 32, 32'h9ABCDEF0, 32, 32});
        run_stream(1'b0, 2'd2);
        wait_valid("t1_wait");
        check("t1_left", frm_left, 32'h12345678);
        check("t1_right", frm_right, 32'h9ABCDEF0);
        pop_one();

        // Left-justified, 16-bit, sign extension
        tx_q.push_back('{32'h00008001, 16, 16, 32'h00007FFF, 16, 16});
        run_stream(1'b1, 2'd0);
        wait_valid("t2_wait");
        check("t2_left", frm_left, 32'hFFFF8001);
        check("t2_right", frm_right, 32'h00007FFF);
        pop_one();

        // Overflow: five frames into a four-deep FIFO with no consumer
        for (int k = 1; k <= 5; k++)
            tx_q.push_back('{32'hA0000000 | 32'(k), 32, 32, 32'h50000000 | 32'(k), 32, 32});
        run_stream(1'b0, 2'd2);
        @(negedge clk);
        check("ovf_set", {31'd0, ovf}, 32'd1);
        check("ovf_model", {31'd0, ovf}, {31'd0, model_ovf});
        pulse_clr();
        model_ovf = 1'b0;
        check("ovf_clr", {31'd0, ovf}, 32'd0);
        check("ovf_head_left", frm_left, 32'hA0000001);
        for (int k = 0; k < 4; k++) begin
            wait_valid("ovf_drain");
            pop_one();
        end
        @(negedge clk);
        check("ovf_drained", {31'd0, frm_valid}, 32'd0);

        // Abort: start mid-right-word, drop enable halfway through a left word
        @(posedge clk); #1;
        fmt = 1'b0; wlen = 2'd2; en = 1'b1;
        cur_fmt = 1'b0; carry = 1'b0;
        send_slot(1'b1, 32'hDEADBEEF, 32, 12);
        send_slot(1'b0, 32'hCAFEF00D, 32, 16);
        @(negedge clk);
        check("abort_busy_on", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_off", {31'd0, busy}, 32'd0);
        send_slot(1'b0, 32'd0, 0, 16);
        send_slot(1'b1, 32'h13572468, 32, 32);
        send_slot(1'b0, 32'd0, 0, 2);
        repeat (4) @(negedge clk);
        check("abort_no_push", {31'd0, frm_valid}, 32'd0);
        check("abort_no_ovf", {31'd0, ovf}, 32'd0);

        // Philips, 24-bit length with 32-bit slots: extra bits ignored
        tx_q.push_back('{32'hAABBCCDD, 32, 32, 32'hAABBCCDD, 32, 32});
        run_stream(1'b0, 2'd1);
        wait_valid("t5_wait");
        check("t5_left", frm_left, 32'hFFAABBCC);
        check("t5_right", frm_right, 32'hFFAABBCC);
        pop_one();

`ifdef I2S_RX_LENCHK_EN
        // Short left word under 32-bit length
        check("len_pre", {31'd0, len_err}, 32'd0);
        tx_q.push_back('{32'h000ABCDE, 20, 20, 32'h13572468, 32, 32});
        run_stream(1'b0, 2'd2);
        wait_valid("t6_wait");
        check("len_set", {31'd0, len_err}, 32'd1);
        check("t6_left", frm_left, 32'hABCDE000);
        check("t6_right", frm_right, 32'h13572468);
        pop_one();
        pulse_clr();
        check("len_clr", {31'd0, len_err}, 32'd0);
`endif

        repeat (4) @(negedge clk);
        check("final_empty", {31'd0, frm_valid}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
